// File: rtl/axis_fifo_bist.sv
// Built-in self-test for the DDR3 AXI-Stream FIFO: LFSR generator on the write side, chunked LFSR checker on the read side.
// Optional error injection on the generator stream is enabled by defining BIST_ERR_INJECT_EN.
module axis_fifo_bist #(
    parameter int          DATA_WIDTH     = 16,
    parameter int          BURST_LEN      = 512,
    parameter int          RD_CHUNK       = 256,
    parameter int          GAP_CYCLES     = 250,
    parameter int          TIMEOUT_CYCLES = 65536,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1,
    parameter int          ERR_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calib_done,
    input  logic                  start,
`ifdef BIST_ERR_INJECT_EN
    input  logic                  inject_err,
`endif
    output logic                  m_axis_tvaild,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  s_axis_tvaild,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [15:0]           first_err_idx
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int KW = $clog2(RD_CHUNK + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
    localparam logic [KW-1:0] CHUNK_C = KW'(RD_CHUNK);
    localparam logic [GW-1:0] GAP_C   = GW'(GAP_CYCLES);
    localparam logic [IW-1:0] IDLE_C  = IW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t          state;
    logic [31:0]     lfsr_tx;
    logic [31:0]     lfsr_rx;
    logic [CW-1:0]   tx_cnt;
    logic [CW-1:0]   rx_cnt;
    logic [KW-1:0]   chunk_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            to_hit;
    logic            inj_armed;

    logic            gen_beat;
    logic            chk_beat;
    logic            launch;
    logic            mismatch;
    logic [CW-1:0]   tx_next;
    logic [CW-1:0]   rx_next;
    logic [KW-1:0]   chunk_next;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Both ports use plain AXI-Stream: a beat transfers on any rising edge where
    // valid && ready; a presented beat's data never changes until it transfers.
    assign gen_beat   = m_axis_tvaild && m_axis_tready;
    assign chk_beat   = s_axis_tvaild && s_axis_tready;
    assign launch     = start && calib_done && (state != ST_RUN);
    assign mismatch   = s_axis_tdata != lfsr_rx[DATA_WIDTH-1:0];
    assign tx_next    = tx_cnt + CW'(1);
    assign rx_next    = rx_cnt + CW'(1);
    assign chunk_next = chunk_cnt + KW'(1);

    assign m_axis_tdata = m_axis_tvaild ?
                          (lfsr_tx[DATA_WIDTH-1:0] ^ DATA_WIDTH'(inj_armed)) : '0;

`ifdef BIST_ERR_INJECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_armed <= 1'b0;
        end else if (gen_beat && inj_armed) begin
            inj_armed <= 1'b0;
        end else if (inject_err) begin
            inj_armed <= 1'b1;
        end
    end
`else
    assign inj_armed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            lfsr_tx       <= LFSR_SEED;
            lfsr_rx       <= LFSR_SEED;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            chunk_cnt     <= '0;
            gap_cnt       <= '0;
            idle_cnt      <= '0;
            to_hit        <= 1'b0;
            m_axis_tvaild <= 1'b0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= 16'hFFFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state         <= ST_RUN;
                        lfsr_tx       <= LFSR_SEED;
                        lfsr_rx       <= LFSR_SEED;
                        tx_cnt        <= '0;
                        rx_cnt        <= '0;
                        chunk_cnt     <= '0;
                        gap_cnt       <= '0;
                        idle_cnt      <= '0;
                        to_hit        <= 1'b0;
                        m_axis_tvaild <= 1'b1;
                        s_axis_tready <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_cnt       <= '0;
                        first_err_idx <= 16'hFFFF;
                    end else if (state == ST_DONE && !done) begin
                        // Result flags settle one cycle after the run ends so the last compare is included.
                        done    <= 1'b1;
                        timeout <= to_hit;
                        pass    <= !to_hit && (err_cnt == '0) && (rx_cnt == BURST_C);
                    end
                end

                ST_RUN: begin
                    if (gen_beat) begin
                        lfsr_tx <= lfsr_step(lfsr_tx);
                        tx_cnt  <= tx_next;
                        if (tx_next == BURST_C) begin
                            m_axis_tvaild <= 1'b0;
                        end
                    end

                    if (gen_beat || chk_beat) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end

                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                        if (gap_cnt == GW'(1)) begin
                            s_axis_tready <= 1'b1;
                        end
                    end

                    if (chk_beat) begin
                        lfsr_rx <= lfsr_step(lfsr_rx);
                        rx_cnt  <= rx_next;
                        if (mismatch) begin
                            if (err_cnt == '0) begin
                                first_err_idx <= 16'(rx_cnt);
                            end
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                        end
                        if (chunk_next == CHUNK_C) begin
                            chunk_cnt <= '0;
                            if (GAP_CYCLES > 0) begin
                                s_axis_tready <= 1'b0;
                                gap_cnt       <= GAP_C;
                            end
                        end else begin
                            chunk_cnt <= chunk_next;
                        end
                    end

                    // Completion has priority over a coincident timeout.
                    if (chk_beat && rx_next == BURST_C) begin
                        state         <= ST_DONE;
                        busy          <= 1'b0;
                        m_axis_tvaild <= 1'b0;
                        s_axis_tready <= 1'b0;
                        gap_cnt       <= '0;
                        to_hit        <= 1'b0;
                    end else if (idle_cnt == IDLE_C && !gen_beat && !chk_beat) begin
                        state         <= ST_DONE;
                        busy          <= 1'b0;
                        m_axis_tvaild <= 1'b0;
                        s_axis_tready <= 1'b0;
                        gap_cnt       <= '0;
                        to_hit        <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_fifo_bist.sv
// Bench for axis_fifo_bist: behavioural FIFO plus a stream-level model of the self-test outcome, checked every cycle.
module tb_axis_fifo_bist;

  localparam int BURST = 512;
  localparam int CHUNK = 256;
  localparam int GAP   = 250;
  localparam int TO    = 1000;
  localparam logic [31:0] SEED = 32'hACE1;

  // clock / reset
  logic clk;
  logic rst;
  logic calib_done;
  logic start;
  logic m_axis_tvaild;
  logic m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic s_axis_tvaild;
  logic s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic busy;
  logic done;
  logic pass;
  logic timeout;
  logic [15:0] err_cnt;
  logic [15:0] first_err_idx;
`ifdef BIST_ERR_INJECT_EN
  logic inject_err;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  axis_fifo_bist #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .calib_done    (calib_done),
    .start         (start),
`ifdef BIST_ERR_INJECT_EN
    .inject_err    (inject_err),
`endif
    .m_axis_tvaild (m_axis_tvaild),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .s_axis_tvaild (s_axis_tvaild),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  // model and scoreboard state
  logic [15:0] words [0:BURST-1];
  logic [15:0] fifo_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_ctrl = 1;
  bit running = 0;
  bit flag_delay = 0;
  bit done_e = 0;
  bit pass_e = 0;
  bit to_e = 0;
  logic [15:0] err_e = 16'h0;
  logic [15:0] first_e = 16'hFFFF;
  int gap_left = 0;
  int tx_n = 0;
  int rx_n = 0;
  bit rd_en = 1;
  int ready_mode = 0;
  int corrupt_idx = -1;
  bit prev_stall = 0;
  logic [15:0] prev_data = 16'h0;
  bit start_req = 0;
  bit rst_req = 1;
  bit inj_req = 0;
  bit inj_armed_e = 0;
  int low_cnt = 0;
  int start_step = 0;
  int first_gen_step = 0;
  int last_gen_step = 0;
  int last_rx_step = 0;
  int done_step = 0;
  logic [15:0] word0_seen = 16'h0;
  logic [15:0] word1_seen = 16'h0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare outputs with the model, drive FIFO-side inputs,
  // then advance the model by the beats that the coming edge will transfer.
  task automatic step();
    bit g;
    bit c;
    bit was_running;
    logic [15:0] d;
    @(negedge clk);
    cyc++;
    if (chk_ctrl) begin
      check("busy", busy, running);
      check("done", done, done_e);
      check("pass", pass, pass_e);
      check("timeout", timeout, to_e);
      check("err_cnt", err_cnt, err_e);
      check("first_err_idx", first_err_idx, first_e);
      check("s_tready", s_axis_tready, running && gap_left == 0);
      check("m_tvalid", m_axis_tvaild, running && tx_n < BURST);
    end
    if (prev_stall) check("tdata_hold", m_axis_tdata, prev_data);
    if (running && !s_axis_tready) low_cnt++;

    rst = rst_req;
    start = start_req;
    start_req = 0;
`ifdef BIST_ERR_INJECT_EN
    inject_err = inj_req;
`endif
    m_axis_tready = (ready_mode == 0) || (cyc % 3 == 0);
    if (rd_en && fifo_q.size() > 0) begin
      d = fifo_q[0];
      if (rx_n == corrupt_idx) d[3] = ~d[3];
      s_axis_tvaild = 1'b1;
      s_axis_tdata = d;
    end else begin
      s_axis_tvaild = 1'b0;
      s_axis_tdata = 16'h0;
    end

    if (rst) begin
      running = 0; flag_delay = 0; done_e = 0; pass_e = 0; to_e = 0;
      err_e = 16'h0; first_e = 16'hFFFF; gap_left = 0; tx_n = 0; rx_n = 0;
      prev_stall = 0; inj_armed_e = 0; fifo_q.delete();
    end else begin
      was_running = running;
      g = m_axis_tvaild && m_axis_tready;
      c = s_axis_tvaild && s_axis_tready;
      prev_stall = m_axis_tvaild && !m_axis_tready;
      prev_data = m_axis_tdata;
      if (g) begin
        if (tx_n < BURST) check("tx_data", m_axis_tdata, words[tx_n] ^ {15'h0, inj_armed_e});
        else check("tx_extra_beat", 1, 0);
        if (tx_n == 0) begin first_gen_step = cyc; word0_seen = m_axis_tdata; end
        if (tx_n == 1) word1_seen = m_axis_tdata;
        fifo_q.push_back(m_axis_tdata);
        last_gen_step = cyc;
        tx_n++;
      end
      if (g && inj_armed_e) inj_armed_e = 0;
      else if (inj_req) inj_armed_e = 1;
      if (flag_delay) begin
        done_e = 1; to_e = 0; pass_e = (err_e == 0) && (rx_n == BURST); flag_delay = 0;
      end
      if (running && gap_left > 0) gap_left--;
      if (c) begin
        void'(fifo_q.pop_front());
        if (rx_n < BURST && s_axis_tdata != words[rx_n]) begin
          if (err_e == 0) first_e = 16'(rx_n);
          if (err_e != 16'hFFFF) err_e = err_e + 16'h1;
        end
        rx_n++;
        last_rx_step = cyc;
        if (rx_n == BURST) begin
          running = 0; flag_delay = 1;
        end else if (rx_n % CHUNK == 0 && GAP > 0) begin
          gap_left = GAP;
        end
      end
      if (start && calib_done && !was_running) begin
        running = 1; flag_delay = 0; done_e = 0; pass_e = 0; to_e = 0;
        err_e = 16'h0; first_e = 16'hFFFF; gap_left = 0; tx_n = 0; rx_n = 0;
        low_cnt = 0; start_step = cyc;
      end
    end
    inj_req = 0;
  endtask

  // driver tasks
  task automatic launch_run();
    start_req = 1;
    step();
    step();
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done === 1'b1) begin seen = 1; done_step = cyc; end
    end
    if (!seen) check("done_wait_expired", 0, 1);
  endtask

  task automatic check_result(input string tag, input bit exp_pass, input logic [15:0] exp_err,
                              input logic [15:0] exp_first);
    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_first_err"}, first_err_idx, exp_first);
    check({tag, "_tx_beats"}, tx_n, BURST);
    check({tag, "_rx_beats"}, rx_n, BURST);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err"}, first_err_idx, 16'hFFFF);
    check({tag, "_m_tvalid"}, m_axis_tvaild, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
  endtask

  initial begin
    logic [31:0] s;
    rst = 1'b1; calib_done = 1'b0; start = 1'b0;
    m_axis_tready = 1'b0; s_axis_tvaild = 1'b0; s_axis_tdata = 16'h0;
`ifdef BIST_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    s = SEED;
    for (int i = 0; i < BURST; i++) begin
      words[i] = s[15:0];
      s = lfsr_next(s);
    end
    check("model_word1", words[1], 16'h59C3);
    check("model_word2", words[2], 16'hB386);

    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();
    check_reset_state("reset");

    // start is ignored until calibration completes
    start_req = 1;
    repeat (3) step();
    check("start_no_calib", busy, 0);
    calib_done = 1'b1;
    step();

    // always-ready write side, default chunk/gap on the read side, extra start mid-run
    launch_run();
    repeat (50) step();
    check("busy_mid_run", busy, 1);
    start_req = 1;
    wait_done(3000);
    check_result("t1", 1, 16'h0, 16'hFFFF);
    check("t1_first_word", word0_seen, 16'hACE1);
    check("t1_second_word", word1_seen, 16'h59C3);
    check("t1_first_beat_latency", first_gen_step - start_step, 1);
    check("t1_done_latency", done_step - last_rx_step, 2);
    check("t1_gap_low_cycles", low_cnt, GAP);
    repeat (5) step();
    check("t1_done_held", done, 1);

    // write side ready one cycle in three
    ready_mode = 1;
    launch_run();
    wait_done(5000);
    check_result("t2", 1, 16'h0, 16'hFFFF);
    check("t2_gap_low_cycles", low_cnt, GAP);
    ready_mode = 0;
    step();

    // read beat 100 corrupted in bit 3
    corrupt_idx = 100;
    launch_run();
    wait_done(3000);
    check_result("t4", 0, 16'h1, 16'd100);
    corrupt_idx = -1;
    step();

    // read side starved: run must abort on the idle timeout
    rd_en = 0;
    chk_ctrl = 0;
    launch_run();
    wait_done(4000);
    check("t5_done", done, 1);
    check("t5_timeout", timeout, 1);
    check("t5_pass", pass, 0);
    check("t5_busy", busy, 0);
    check("t5_tx_beats", tx_n, BURST);
    check("t5_timeout_window", (done_step - last_gen_step >= 998) && (done_step - last_gen_step <= 1006), 1);
    running = 0; flag_delay = 0; gap_left = 0; done_e = 1; pass_e = 0; to_e = 1;
    err_e = 16'h0; first_e = 16'hFFFF; rx_n = 0;
    fifo_q.delete();
    rd_en = 1;
    chk_ctrl = 1;
    repeat (3) step();

    // reset in the middle of a run, then a clean rerun from the seed
    launch_run();
    for (int i = 0; i < 2000 && rx_n < 200; i++) step();
    check("t6_reached_200", rx_n >= 200, 1);
    rst_req = 1;
    repeat (2) step();
    rst_req = 0;
    step();
    check_reset_state("t6_reset");
    launch_run();
    wait_done(3000);
    check_result("t6", 1, 16'h0, 16'hFFFF);
    check("t6_first_word", word0_seen, 16'hACE1);

`ifdef BIST_ERR_INJECT_EN
    inj_req = 1;
    step();
    inj_req = 1;
    step();
    launch_run();
    wait_done(3000);
    check_result("t6_inject", 0, 16'h1, 16'h0);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
